// File: rtl/mac_accumulator.sv
// Packet multiply-accumulate: each accepted beat contributes in_a*in_x to a running
// sum; the sum, beat count and overflow flag are held on the output until taken.

module array_multiplier #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] p_o
);
  // Row i adds the partial product a*b[i] into the running sum of rows 0..i-1.
  logic [2*WIDTH-1:0] row [WIDTH+1];

  assign row[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [2*WIDTH-1:0] pp;
    assign pp         = b_i[i] ? ((2*WIDTH)'(a_i) << i) : '0;
    assign row[i + 1] = row[i] + pp;
  end

  assign p_o = row[WIDTH];
endmodule

module mac_accumulator #(
  parameter int WIDTH     = 25,
  parameter int ACC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_x,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [15:0]          out_count,
  output logic                 out_ovf,
  output logic [1:0]           dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the producer holds its payload while stalled.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state_q;
  logic                 s1_valid_q;
  logic                 s1_last_q;
  logic [WIDTH-1:0]     s1_a_q;
  logic [WIDTH-1:0]     s1_x_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [15:0]          count_q;
  logic                 ovf_q;

  logic [2*WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]   sum_d;
  logic [15:0]          count_d;
  logic                 accept;

  array_multiplier #(.WIDTH(WIDTH)) u_mult (
    .a_i (s1_a_q),
    .b_i (s1_x_q),
    .p_o (prod)
  );

  assign prod_ext = ACC_WIDTH'(prod);
  assign sum_d    = {1'b0, acc_q} + {1'b0, prod_ext};
  assign count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  // A last beat sitting in stage 1 blocks intake so the next packet cannot mix in.
  assign in_ready = (state_q != HOLD) && !(s1_valid_q && s1_last_q);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_x_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q    <= in_a;
        s1_x_q    <= in_x;
        s1_last_q <= in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s1_valid_q) begin
            acc_q   <= prod_ext;
            count_q <= 16'd1;
            ovf_q   <= 1'b0;
            state_q <= s1_last_q ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (s1_valid_q) begin
            acc_q   <= sum_d[ACC_WIDTH-1:0];
            ovf_q   <= ovf_q | sum_d[ACC_WIDTH];
            count_q <= count_d;
            if (s1_last_q) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_valid ? acc_q   : '0;
  assign out_count = out_valid ? count_q : '0;
  assign out_ovf   = out_valid & ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: table of packets with hand-computed results,
// plus hand-written sequences for overflow, output stall and reset corners.

module tb_mac_accumulator;
  localparam int W = 25;
  localparam logic [W-1:0] MAXV = 25'h1FFFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_last, out_ready;
  logic [W-1:0]  in_a, in_x;
  logic          in_ready, out_valid, out_ovf;
  logic [63:0]   out_sum;
  logic [15:0]   out_count;
  logic [1:0]    dbg_state;
  logic          in_ready50, out_valid50, out_ovf50;
  logic [49:0]   out_sum50;
  logic [15:0]   out_count50;
  logic [1:0]    dbg_state50;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.WIDTH(25), .ACC_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_x(in_x), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  mac_accumulator #(.WIDTH(25), .ACC_WIDTH(50)) dut50 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready50),
    .in_a(in_a), .in_x(in_x), .in_last(in_last), .out_valid(out_valid50),
    .out_ready(out_ready), .out_sum(out_sum50), .out_count(out_count50),
    .out_ovf(out_ovf50), .dbg_state(dbg_state50)
  );

  typedef struct {
    int                n;
    logic [2:0][W-1:0] a;
    logic [2:0][W-1:0] x;
    logic [63:0]       sum;
    logic [15:0]       cnt;
    logic              ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_x      = '0;
    out_ready = 1'b0;
  endtask

  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] x, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_x     = x;
    in_last  = last;
    check("in_ready_before_beat", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Last beat presented in the cycle ending at edge N: stage 1 captures it at N,
  // the state machine reaches HOLD at N+1.
  task automatic wait_result();
    check("out_valid_one_edge_after_last", 64'(out_valid), 64'd0);
    check("in_ready_blocked_by_last", 64'(in_ready), 64'd0);
    step();
    check("out_valid_two_edges_after_last", 64'(out_valid), 64'd1);
    check("state_hold", 64'(dbg_state), 64'd2);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_take", 64'(out_valid), 64'd0);
    check("in_ready_after_take", 64'(in_ready), 64'd1);
  endtask

  task automatic run_packet(input vec_t v);
    for (int b = 0; b < v.n; b++) drive_beat(v.a[b], v.x[b], b == v.n - 1);
    wait_result();
    check("out_sum", out_sum, v.sum);
    check("out_count", 64'(out_count), 64'(v.cnt));
    check("out_ovf", 64'(out_ovf), 64'(v.ovf));
    take_result();
  endtask

  initial begin
    vecs[0].n = 3; vecs[0].a = {25'd7, 25'd5, 25'd3}; vecs[0].x = {25'd8, 25'd6, 25'd4};
    vecs[0].sum = 64'd98; vecs[0].cnt = 16'd3; vecs[0].ovf = 1'b0;
    vecs[1].n = 1; vecs[1].a = {25'd0, 25'd0, MAXV}; vecs[1].x = {25'd0, 25'd0, MAXV};
    vecs[1].sum = 64'h3FFFFFC000001; vecs[1].cnt = 16'd1; vecs[1].ovf = 1'b0;
    vecs[2].n = 2; vecs[2].a = {25'd0, 25'd9, 25'd0}; vecs[2].x = {25'd0, 25'd0, 25'd12345};
    vecs[2].sum = 64'd0; vecs[2].cnt = 16'd2; vecs[2].ovf = 1'b0;
    vecs[3].n = 2; vecs[3].a = {25'd0, 25'd2, 25'd1000}; vecs[3].x = {25'd0, 25'd3, 25'd1000};
    vecs[3].sum = 64'd1000006; vecs[3].cnt = 16'd2; vecs[3].ovf = 1'b0;
    vecs[4].n = 1; vecs[4].a = {25'd0, 25'd0, MAXV}; vecs[4].x = {25'd0, 25'd0, 25'd1};
    vecs[4].sum = 64'd33554431; vecs[4].cnt = 16'd1; vecs[4].ovf = 1'b0;

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_sum", out_sum, 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_packet(vecs[i]);

    // Two full-scale beats: fits in 64 bits, wraps a 50-bit accumulator.
    drive_beat(MAXV, MAXV, 1'b0);
    drive_beat(MAXV, MAXV, 1'b1);
    wait_result();
    check("ovf64_sum", out_sum, 64'h7FFFFF8000002);
    check("ovf64_flag", 64'(out_ovf), 64'd0);
    check("ovf50_valid", 64'(out_valid50), 64'd1);
    check("ovf50_sum", 64'(out_sum50), 64'h3FFFFF8000002);
    check("ovf50_count", 64'(out_count50), 64'd2);
    check("ovf50_flag", 64'(out_ovf50), 64'd1);
    take_result();

    // Output stalled in HOLD while the next packet's beat waits at the input.
    drive_beat(25'd3, 25'd4, 1'b1);
    wait_result();
    in_valid = 1'b1; in_a = 25'd5; in_x = 25'd5; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_sum", out_sum, 64'd12);
      check("stall_count", 64'(out_count), 64'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("stall_released_valid", 64'(out_valid), 64'd0);
    check("stall_beat_not_taken", 64'(dbg_state), 64'd0);
    check("stall_in_ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    wait_result();
    check("after_stall_sum", out_sum, 64'd25);
    check("after_stall_count", 64'(out_count), 64'd1);
    take_result();

    // out_ready with nothing presented must do nothing.
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("idle_out_ready_valid", 64'(out_valid), 64'd0);
    check("idle_out_ready_state", 64'(dbg_state), 64'd0);

    // Reset mid-packet, then a fresh one-beat packet.
    drive_beat(25'd10, 25'd10, 1'b0);
    drive_beat(25'd20, 25'd20, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    step();
    drive_beat(25'd1, 25'd1, 1'b1);
    wait_result();
    check("postrst_sum", out_sum, 64'd1);
    check("postrst_count", 64'(out_count), 64'd1);
    take_result();

    // Reset while a result is pending discards it.
    drive_beat(25'd2, 25'd2, 1'b1);
    wait_result();
    rst = 1'b1;
    #1;
    check("holdrst_valid", 64'(out_valid), 64'd0);
    check("holdrst_sum", out_sum, 64'd0);
    step();
    rst = 1'b0;
    step();
    drive_beat(25'd6, 25'd7, 1'b1);
    wait_result();
    check("holdrst_next_sum", out_sum, 64'd42);
    check("holdrst_next_count", 64'(out_count), 64'd1);
    take_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
